// File: rtl/serial_mag_comp_pkg.sv
// Shared types and constants for the nibble-serial magnitude comparator.
package serial_mag_comp_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Sticky decision: set on the first unequal nibble, then frozen.
    typedef enum logic [1:0] {
        DecNone,
        DecGt,
        DecLt
    } dec_e;

endpackage

// File: rtl/nib_cmp4.sv
// Combinational 4-bit unsigned magnitude compare; exactly one output is high.
module nib_cmp4
    import serial_mag_comp_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    output logic                eq_o,
    output logic                gt_o,
    output logic                lt_o
);

    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/serial_mag_comp.sv
// Nibble-serial unsigned compare, MSB nibble first, with sticky decision.
// Define SERIAL_MAG_COMP_EARLY_EXIT_EN to finish right after the first unequal nibble.
module serial_mag_comp
    import serial_mag_comp_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             aeb,
    output logic             agb,
    output logic             alb
);

    localparam int unsigned NIB  = WIDTH / NIBBLE_W;
    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    dec_e             dec_q, dec_d;
    // {aeb, agb, alb}
    logic [2:0]       res_q, res_d;

    logic [NIB-1:0][NIBBLE_W-1:0] a_nib, b_nib;
    logic [NIBBLE_W-1:0]          nib_a, nib_b;
    logic                         cmp_eq, cmp_gt, cmp_lt;
    logic                         run_exit;

    assign a_nib = a_q;
    assign b_nib = b_q;
    assign nib_a = a_nib[idx_q];
    assign nib_b = b_nib[idx_q];

    nib_cmp4 u_nib_cmp4 (
        .a_i  (nib_a),
        .b_i  (nib_b),
        .eq_o (cmp_eq),
        .gt_o (cmp_gt),
        .lt_o (cmp_lt)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        dec_d    = dec_q;
        res_d    = res_q;
        run_exit = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IdxW'(NIB - 1);
                    dec_d   = DecNone;
                end
            end
            RUN: begin
                if (dec_q == DecNone && !cmp_eq) begin
                    if (cmp_gt) begin
                        dec_d = DecGt;
                    end else if (cmp_lt) begin
                        dec_d = DecLt;
                    end
                end
`ifdef SERIAL_MAG_COMP_EARLY_EXIT_EN
                run_exit = (idx_q == '0) || (dec_d != DecNone);
`else
                run_exit = (idx_q == '0);
`endif
                if (run_exit) begin
                    state_d = DONE;
                    unique case (dec_d)
                        DecGt:   res_d = 3'b010;
                        DecLt:   res_d = 3'b001;
                        default: res_d = 3'b100;
                    endcase
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dec_q   <= DecNone;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dec_q   <= dec_d;
            res_q   <= res_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign aeb  = res_q[2];
    assign agb  = res_q[1];
    assign alb  = res_q[0];

endmodule
